mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer between the LC-3 datapath's MAR/MDR registers and the external asynchronous SRAM. Accepts one read or write request per transaction from the control unit, drives SRAM strobes for a fixed number of wait cycles, and returns read data that feeds the MDR input mux's MEM2IO leg. Optionally decodes one memory-mapped I/O word for board switches and the hex display.

## Interface
- WAIT_CYCLES, 2: extra SRAM access cycles beyond the first (legal 0..7).
- MMIO_ADDR, 16'hFFFF: address of the I/O word (used only with MMIO compiled in).
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  controller can accept a request.
- Req_WE  in  1  1 = write, 0 = read.
- Req_Addr  in  16  word address (from MAR).
- Req_WData  in  16  write data (from MDR).
- Rsp_Valid  out  1  one-cycle completion pulse (read or write).
- Rsp_RData  out  16  read data to MDR mux MEM2IO input.
- Mem_Addr  out  16  SRAM address.
- Mem_WData  out  16  SRAM write data.
- Mem_RData  in  16  SRAM read data.
- Mem_CE_n, Mem_OE_n, Mem_WE_n  out  1 each  SRAM strobes, active-low.
- Switches  in  16  board switches (asynchronous).
- Hex_Data  out  16  value shown on hex display.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: Req_Ready = 1. Handshake completes on a rising edge with Req_Valid & Req_Ready; capture Req_WE, Req_Addr, Req_WData into Mem_* registers; load wait counter with WAIT_CYCLES; go ACCESS.
- ACCESS: Mem_CE_n = 0; read: Mem_OE_n = 0, Mem_WE_n = 1; write: Mem_WE_n = 0, Mem_OE_n = 1. Counter decrements each cycle. On the edge where counter == 0: reads latch Mem_RData into Rsp_RData; go DONE.
- DONE: strobes all 1, Mem_Addr/Mem_WData held; Rsp_Valid = 1 for exactly this cycle; next state IDLE.
- Req_Ready = 0 in ACCESS and DONE; requests offered there are ignored (not queued).
- Writes leave Rsp_RData unchanged.
- Counter is 3 bits; WAIT_CYCLES outside 0..7 is a parameter error (elaboration assertion).

## Timing
- Reset values: state IDLE, Req_Ready 0 while Reset_n low, Rsp_Valid 0, Rsp_RData 0, Mem_Addr 0, Mem_WData 0, all strobes 1, Hex_Data 0.
- All outputs except Req_Ready are registered; Req_Ready = (state == IDLE).
- Request accepted at edge E: ACCESS spans cycles E+1..E+1+WAIT_CYCLES; Rsp_Valid high in cycle E+2+WAIT_CYCLES; next acceptance earliest at edge E+3+WAIT_CYCLES.
- WAIT_CYCLES = 0: ACCESS lasts exactly one cycle.
- Reset_n asserted mid-transaction: strobes return to 1 immediately (asynchronously), transaction dropped, no Rsp_Valid.

## Configuration
- Macro MEM_ACCESS_MMIO_EN.
- Defined: Req_Addr == MMIO_ADDR skips ACCESS (no SRAM strobes, IDLE -> DONE); read returns Switches after a 2-flop synchronizer; write loads Hex_Data with Req_WData. Rsp_Valid one cycle after acceptance.
- Undefined: MMIO_ADDR is ordinary SRAM; Switches unused; Hex_Data held at 0.

## Structure
- Package lc3_mem_pkg: state enum (IDLE/ACCESS/DONE), default MMIO_ADDR constant, wait-counter width constant.
- One sub-module: sync2 (16-bit two-flop synchronizer for Switches), instantiated only under MEM_ACCESS_MMIO_EN.

## Test plan
- Read, WAIT_CYCLES=2, Addr 16'h0030, Mem_RData 16'hBEEF -> OE_n/CE_n low 3 cycles, Rsp_Valid at E+4, Rsp_RData 16'hBEEF.
- Write, Addr 16'h0031, WData 16'h1234 -> WE_n low 3 cycles, Mem_Addr/Mem_WData stable through DONE, Rsp_Valid once, Rsp_RData unchanged.
- Back-to-back Req_Valid held high -> accepts spaced WAIT_CYCLES+3 edges apart, Req_Ready 0 between.
- WAIT_CYCLES=0 read -> single ACCESS cycle, Rsp_Valid at E+2.
- Reset_n pulsed low during ACCESS -> strobes 1 immediately, no Rsp_Valid, Req_Ready 1 after release.
- MMIO_EN: write 16'h00A5 to 16'hFFFF -> Hex_Data 16'h00A5, no strobes; read with Switches 16'h0F0F -> Rsp_RData 16'h0F0F at E+2.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access sequencer.
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;
   localparam int          CNT_W             = 3;

endpackage

// File: rtl/mem_access_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous board switches into the clock domain.
module sync2 #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR to asynchronous SRAM sequencer with fixed wait states.
// Optional memory-mapped switch/hex word when MEM_ACCESS_MMIO_EN is defined.
module mem_access_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   input  logic        Req_WE,
   input  logic [15:0] Req_Addr,
   input  logic [15:0] Req_WData,
   output logic        Rsp_Valid,
   output logic [15:0] Rsp_RData,
   output logic [15:0] Mem_Addr,
   output logic [15:0] Mem_WData,
   input  logic [15:0] Mem_RData,
   output logic        Mem_CE_n,
   output logic        Mem_OE_n,
   output logic        Mem_WE_n,
   input  logic [15:0] Switches,
   output logic [15:0] Hex_Data
);

   mem_state_t       state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             op_we, op_we_nx;
   logic             handshake, is_mmio;
   logic             ce_n_nx, oe_n_nx, we_n_nx;
   logic [15:0]      mmio_rdata;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
      $error("mem_access_ctrl: WAIT_CYCLES must be in 0..7");
   end

   assign Req_Ready = Reset_n && (state == IDLE);
   assign handshake = (state == IDLE) && Req_Valid;

`ifdef MEM_ACCESS_MMIO_EN
   sync2 #(.WIDTH(16)) u_sync2 (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .d       (Switches),
      .q       (mmio_rdata)
   );

   assign is_mmio = (Req_Addr == MMIO_ADDR);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Hex_Data <= '0;
      end else if (handshake && is_mmio && Req_WE) begin
         Hex_Data <= Req_WData;
      end
   end
`else
   logic unused_mmio;
   assign unused_mmio = ^{Switches, MMIO_ADDR};
   assign is_mmio     = 1'b0;
   assign mmio_rdata  = '0;
   assign Hex_Data    = '0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // MMIO hits bypass the SRAM entirely and complete on the following cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Req_Valid) next_state = is_mmio ? DONE : ACCESS;
         ACCESS:  if (wait_cnt == '0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      op_we_nx = handshake ? Req_WE : op_we;
      ce_n_nx  = 1'b1;
      oe_n_nx  = 1'b1;
      we_n_nx  = 1'b1;
      if (next_state == ACCESS) begin
         ce_n_nx = 1'b0;
         oe_n_nx = op_we_nx;
         we_n_nx = !op_we_nx;
      end
   end

   // Strobes and the completion pulse are registered from the next state so they align with it.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Mem_Addr  <= '0;
         Mem_WData <= '0;
         Rsp_RData <= '0;
         Rsp_Valid <= 1'b0;
         Mem_CE_n  <= 1'b1;
         Mem_OE_n  <= 1'b1;
         Mem_WE_n  <= 1'b1;
         op_we     <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (handshake) begin
            Mem_Addr  <= Req_Addr;
            Mem_WData <= Req_WData;
            op_we     <= Req_WE;
            wait_cnt  <= CNT_W'(WAIT_CYCLES);
            if (is_mmio && !Req_WE) Rsp_RData <= mmio_rdata;
         end else if (state == ACCESS) begin
            if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
            else if (!op_we)   Rsp_RData <= Mem_RData;
         end
         Rsp_Valid <= (next_state == DONE);
         Mem_CE_n  <= ce_n_nx;
         Mem_OE_n  <= oe_n_nx;
         Mem_WE_n  <= we_n_nx;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a response scoreboard; covers WAIT_CYCLES=2 and 0.
module tb_mem_access_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] switches = '0;

   logic        req_ready, rsp_valid, ce_n, oe_n, we_n;
   logic [15:0] rsp_rdata, mem_addr, mem_wdata, hex_data;
   logic        req_ready0, rsp_valid0, ce_n0, oe_n0, we_n0;
   logic [15:0] rsp_rdata0, mem_addr0, mem_wdata0, hex_data0;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] sb[$];
   logic [15:0] model_rdata = '0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .Clk(clk), .Reset_n(rst_n), .Req_Valid(req_valid), .Req_Ready(req_ready),
      .Req_WE(req_we), .Req_Addr(req_addr), .Req_WData(req_wdata),
      .Rsp_Valid(rsp_valid), .Rsp_RData(rsp_rdata), .Mem_Addr(mem_addr),
      .Mem_WData(mem_wdata), .Mem_RData(mem_rdata), .Mem_CE_n(ce_n),
      .Mem_OE_n(oe_n), .Mem_WE_n(we_n), .Switches(switches), .Hex_Data(hex_data)
   );

   mem_access_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n), .Req_Valid(req_valid), .Req_Ready(req_ready0),
      .Req_WE(req_we), .Req_Addr(req_addr), .Req_WData(req_wdata),
      .Rsp_Valid(rsp_valid0), .Rsp_RData(rsp_rdata0), .Mem_Addr(mem_addr0),
      .Mem_WData(mem_wdata0), .Mem_RData(mem_rdata), .Mem_CE_n(ce_n0),
      .Mem_OE_n(oe_n0), .Mem_WE_n(we_n0), .Switches(switches), .Hex_Data(hex_data0)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic popCheck(input string tag, input logic [15:0] obs);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("[TB] FAIL %s: response with empty scoreboard, observed %h", tag, obs);
      end else begin
         checkOutput(tag, obs, sb.pop_front());
      end
   endtask

   // One full transaction on the W=2 device; optionally also times the W=0 device.
   task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] rd, input bit chk0);
      logic [4:0] exp_v;
      @(negedge clk);
      checkOutput("ready_idle", 16'(req_ready), 16'h0001);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; mem_rdata = rd;
      if (!we) model_rdata = rd;
      sb.push_back(model_rdata);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
      for (int k = 1; k <= W + 2; k++) begin
         if (k > 1) @(negedge clk);
         exp_v = (k <= W + 1) ? {1'b0, 1'b0, we, ~we, 1'b0} : 5'b11110;
         checkOutput("ctl", 16'({rsp_valid, ce_n, oe_n, we_n, req_ready}), 16'(exp_v));
         checkOutput("mem_addr", mem_addr, addr);
         checkOutput("mem_wdata", mem_wdata, wdata);
         if (k == W + 2) popCheck("rsp_rdata", rsp_rdata);
         if (chk0) begin
            exp_v = (k == 1) ? {1'b0, 1'b0, we, ~we, 1'b0} : (k == 2) ? 5'b11110 : 5'b01111;
            checkOutput("ctl_w0", 16'({rsp_valid0, ce_n0, oe_n0, we_n0, req_ready0}), 16'(exp_v));
            if (k == 2) checkOutput("rsp_rdata_w0", rsp_rdata0, rd);
         end
      end
      @(negedge clk);
      checkOutput("after_done", 16'({rsp_valid, req_ready}), 16'h0001);
   endtask

`ifdef MEM_ACCESS_MMIO_EN
   task automatic mmioStep(input logic we, input logic [15:0] wdata, input logic [15:0] exp_hex);
      @(negedge clk);
      checkOutput("mmio_ready", 16'(req_ready), 16'h0001);
      req_valid = 1'b1; req_we = we; req_addr = 16'hFFFF; req_wdata = wdata;
      if (!we) model_rdata = switches;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("mmio_ctl", 16'({rsp_valid, ce_n, oe_n, we_n, req_ready}), 16'h001E);
      checkOutput("mmio_hex", hex_data, exp_hex);
      checkOutput("mmio_rdata", rsp_rdata, model_rdata);
      @(negedge clk);
      checkOutput("mmio_after", 16'({rsp_valid, req_ready}), 16'h0001);
   endtask
`endif

   initial begin
      $display("[TB] start");
      switches = 16'h0F0F;
      repeat (2) @(negedge clk);
      checkOutput("rst_ctl", 16'({rsp_valid, ce_n, oe_n, we_n, req_ready}), 16'h000E);
      checkOutput("rst_ctl_w0", 16'({rsp_valid0, ce_n0, oe_n0, we_n0, req_ready0}), 16'h000E);
      checkOutput("rst_rdata", rsp_rdata, 16'h0000);
      checkOutput("rst_addr", mem_addr, 16'h0000);
      checkOutput("rst_wdata", mem_wdata, 16'h0000);
      checkOutput("rst_hex", hex_data, 16'h0000);
      rst_n = 1'b1;

      applyStimulus(1'b0, 16'h0030, 16'h0000, 16'hBEEF, 1'b1);
      applyStimulus(1'b1, 16'h0031, 16'h1234, 16'h5555, 1'b0);
      applyStimulus(1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0);

      // Request held high: accepts must be W+3 edges apart.
      @(negedge clk);
      checkOutput("b2b_ready0", 16'(req_ready), 16'h0001);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0050; mem_rdata = 16'h1111;
      model_rdata = 16'h1111;
      repeat (3) sb.push_back(16'h1111);
      for (int i = 1; i <= 3 * (W + 3); i++) begin
         @(negedge clk);
         checkOutput("b2b_ctl", 16'({rsp_valid, req_ready}),
                     16'({(i % (W + 3)) == (W + 2), (i % (W + 3)) == 0}));
         if (rsp_valid) popCheck("b2b_rdata", rsp_rdata);
      end
      req_valid = 1'b0;

      // Reset in the middle of an access drops the transaction.
      @(negedge clk);
      checkOutput("mid_ready", 16'(req_ready), 16'h0001);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0060; mem_rdata = 16'h7777;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("mid_access", 16'({rsp_valid, ce_n, oe_n, we_n, req_ready}), 16'h0002);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_strobes", 16'({rsp_valid, ce_n, oe_n, we_n, req_ready}), 16'h000E);
      checkOutput("mid_rst_rdata", rsp_rdata, 16'h0000);
      model_rdata = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         checkOutput("no_rsp", 16'({rsp_valid, req_ready}), 16'h0001);
      end

      applyStimulus(1'b0, 16'h0070, 16'h0000, 16'hABCD, 1'b1);

`ifdef MEM_ACCESS_MMIO_EN
      mmioStep(1'b1, 16'h00A5, 16'h00A5);
      mmioStep(1'b0, 16'h0000, 16'h00A5);
`endif

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $error("[TB] FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
